// File: rtl/median_pkg.sv
// Shared types and constants for the sequential 3x3 median engine.
package median_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMP,
    DROP,
    DONE
  } state_t;

  localparam int unsigned NPIX          = 9;
  localparam int unsigned NCMP          = 8;
  localparam int unsigned NPASS         = 5;
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/median_seq_mce.sv
// Compare-exchange unit: orders two unsigned values into MAX and MIN.
module median_seq_mce
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] MIN
);

  // Ties route A to MAX; either choice is equivalent for equal values.
  always_comb begin
    MAX = A;
    MIN = B;
    if (A < B) begin
      MAX = B;
      MIN = A;
    end
  end

endmodule

// File: rtl/median_seq.sv
// Sequential 3x3 median engine: serial load of nine pixels, five max-finding
// passes through one compare-exchange unit, median presented on valid/ready.
// Optional macro MEDIAN_BYPASS_EN adds BYP: output the centre pixel instead.
module median_seq
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MEDIAN_BYPASS_EN
  ,
  input  logic             BYP
`endif
);

  state_t           state;
  logic [WIDTH-1:0] r [NPIX];
  logic [3:0]       load_cnt;
  logic [2:0]       cmp_cnt;
  logic [2:0]       pass;
  logic [WIDTH-1:0] mce_max;
  logic [WIDTH-1:0] mce_min;
  logic             accept;
  logic             last_load;
  logic             byp_q;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == LOAD);
  assign last_load = (load_cnt == 4'(NPIX - 1));

  median_seq_mce #(.WIDTH(WIDTH)) u_mce (
    .A   (r[8]),
    .B   (r[7]),
    .MAX (mce_max),
    .MIN (mce_min)
  );

`ifdef MEDIAN_BYPASS_EN
  // Bypass request captured with the ninth pixel, released on result handoff.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      byp_q <= 1'b0;
    end else if (accept && last_load) begin
      byp_q <= BYP;
    end else if (state == DONE && out_ready) begin
      byp_q <= 1'b0;
    end
  end

  assign out_data = byp_q ? r[4] : r[8];
`else
  assign byp_q    = 1'b0;
  assign out_data = r[8];
`endif

  // FSM, counters and rotating register bank.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= LOAD;
      load_cnt <= '0;
      cmp_cnt  <= '0;
      pass     <= '0;
      for (int unsigned k = 0; k < NPIX; k++) begin
        r[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            r[0] <= in_data;
            for (int unsigned k = 1; k < NPIX; k++) begin
              r[k] <= r[k-1];
            end
            if (last_load) begin
              load_cnt <= '0;
              cmp_cnt  <= '0;
              pass     <= '0;
              state    <= COMP;
            end else begin
              load_cnt <= load_cnt + 4'd1;
            end
          end
        end
        COMP: begin
          // Bypass spends one idle COMP cycle so the bank is untouched and
          // the centre pixel stays in r[4].
          if (byp_q) begin
            state <= DONE;
          end else begin
            r[8] <= mce_max;
            r[0] <= mce_min;
            for (int unsigned k = 1; k < NPIX - 1; k++) begin
              r[k] <= r[k-1];
            end
            if (cmp_cnt == 3'(NCMP - 1)) begin
              cmp_cnt <= '0;
              state   <= (pass == 3'(NPASS - 1)) ? DONE : DROP;
            end else begin
              cmp_cnt <= cmp_cnt + 3'd1;
            end
          end
        end
        DROP: begin
          r[8] <= r[7];
          r[0] <= '0;
          for (int unsigned k = 1; k < NPIX - 1; k++) begin
            r[k] <= r[k-1];
          end
          pass    <= pass + 3'd1;
          cmp_cnt <= '0;
          state   <= COMP;
        end
        DONE: begin
          if (out_ready) begin
            load_cnt <= '0;
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
